sdf_flux_merger: RTL and testbench

//  Upstream neighbour of the single-port multi-flux SDF wrapper. Accepts FLUX independent untagged

---
 rtl/sdf_flux_merger_pkg.sv | 30 +++
 rtl/sdf_flux_merger_if.sv | 30 +++
 rtl/sdf_tag_fifo.sv | 63 ++++++
 rtl/sdf_flux_merger.sv | 86 ++++++++
 tb/tb_sdf_flux_merger.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/sdf_flux_merger_pkg.sv
// Shared tag-layout constants for the merger, the SDF wrapper and the downstream splitter.
// The merged word is {tag, data} with the tag in the MSBs.
package sdf_flux_merger_pkg;

    localparam int FLUX       = 2;
    localparam int DATA_WIDTH = 8;
    localparam int TAG_WIDTH  = (FLUX > 1) ? $clog2(FLUX) : 1;
    localparam int WIDTH      = DATA_WIDTH + TAG_WIDTH;
    localparam int TAG_LSB    = DATA_WIDTH;
    localparam int TAG_MSB    = WIDTH - 1;
    localparam int DEPTH      = 4;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [TAG_WIDTH-1:0]  tag_t;
    typedef logic [WIDTH-1:0]      word_t;

    function automatic word_t make_word(input tag_t tag, input data_t data);
        make_word = {tag, data};
    endfunction

    // Round-robin successor, modulo FLUX (FLUX need not be a power of two).
    function automatic tag_t next_tag(input tag_t tag);
        if (int'(tag) == FLUX - 1) begin
            next_tag = tag_t'(1'b0);
        end else begin
            next_tag = tag + tag_t'(1'b1);
        end
    endfunction

endpackage

// File: rtl/sdf_flux_merger_if.sv
// Bundles the per-flux input streams and the merged tagged output of sdf_flux_merger.
interface sdf_flux_merger_if;
    import sdf_flux_merger_pkg::*;

    logic [FLUX-1:0]            in_port_write;
    logic [FLUX*DATA_WIDTH-1:0] in_port_datain;
    logic [FLUX-1:0]            in_port_full;
    logic                       out_port_write;
    word_t                      out_port_dataout;
    logic [FLUX-1:0]            out_port_full;

    modport master (
        output in_port_write,
        output in_port_datain,
        output out_port_full,
        input  in_port_full,
        input  out_port_write,
        input  out_port_dataout
    );

    modport slave (
        input  in_port_write,
        input  in_port_datain,
        input  out_port_full,
        output in_port_full,
        output out_port_write,
        output out_port_dataout
    );

endinterface

// File: rtl/sdf_tag_fifo.sv
// Small synchronous FIFO, one per flux. Full/empty come from the registered count only,
// so a same-edge pop never unblocks a push on a full FIFO.
module sdf_tag_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Status and qualified push/pop strobes.
    always_comb begin
        full      = (count_r == (PW+1)'(DEPTH));
        empty     = (count_r == (PW+1)'(0));
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
        head      = mem_r[rd_ptr_r];
    end

    // Pointer and occupancy state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PW'(1'b0);
            rd_ptr_r <= PW'(1'b0);
            count_r  <= (PW+1)'(1'b0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PW+1)'(1'b1);
                2'b01:   count_r <= count_r - (PW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload storage; contents are only observable through a non-empty head.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/sdf_flux_merger.sv
// Buffers FLUX untagged streams, tags each word with its flux index and round-robin merges
// them onto one tagged port, honouring the downstream per-flux full.
module sdf_flux_merger
    import sdf_flux_merger_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    sdf_flux_merger_if.slave  bus
);

    data_t           head_s [FLUX];
    logic [FLUX-1:0] empty_s;
    logic [FLUX-1:0] full_s;
    logic [FLUX-1:0] pop_s;
    logic [FLUX-1:0] eligible_s;
    tag_t            rr_r;
    tag_t            grant_s;
    logic            any_s;

    for (genvar i = 0; i < FLUX; i++) begin : g_flux
        sdf_tag_fifo #(
            .DW    (DATA_WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (bus.in_port_write[i]),
            .din   (bus.in_port_datain[i*DATA_WIDTH +: DATA_WIDTH]),
            .pop   (pop_s[i]),
            .head  (head_s[i]),
            .full  (full_s[i]),
            .empty (empty_s[i])
        );
    end

    // Downstream full for one flux masks only that flux, so there is no head-of-line blocking.
    always_comb begin
        eligible_s       = ~empty_s & ~bus.out_port_full;
        bus.in_port_full = full_s;
    end

    // Round-robin grant: first eligible flux scanning upward from the pointer.
    always_comb begin
        int   idx;
        tag_t cand;
        idx     = 0;
        cand    = tag_t'(1'b0);
        grant_s = tag_t'(1'b0);
        any_s   = 1'b0;
        for (int k = 0; k < FLUX; k++) begin
            idx  = (int'(rr_r) + k) % FLUX;
            cand = tag_t'(idx);
            if (!any_s && eligible_s[cand]) begin
                any_s   = 1'b1;
                grant_s = cand;
            end else begin
                any_s   = any_s;
            end
        end
    end

    // Output mux and pop strobe for the granted flux.
    always_comb begin
        pop_s                = {FLUX{1'b0}};
        bus.out_port_write   = any_s;
        bus.out_port_dataout = {WIDTH{1'b0}};
        if (any_s) begin
            pop_s[grant_s]       = 1'b1;
            bus.out_port_dataout = make_word(grant_s, head_s[grant_s]);
        end else begin
            bus.out_port_dataout = {WIDTH{1'b0}};
        end
    end

    // Round-robin pointer advances past the flux just served; holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_r <= tag_t'(1'b0);
        end else if (any_s) begin
            rr_r <= next_tag(grant_s);
        end else begin
            rr_r <= rr_r;
        end
    end

endmodule

// File: tb/tb_sdf_flux_merger.sv
// Scoreboard bench for sdf_flux_merger: queue-based reference model, directed scenarios, random traffic.
module tb_sdf_flux_merger;
    import sdf_flux_merger_pkg::*;

    logic clk;
    logic rst;
    sdf_flux_merger_if bus();

    sdf_flux_merger dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            w;
        word_t           d;
        logic [FLUX-1:0] inf;
    } exp_t;

    exp_t  sbq [$];
    data_t mq [FLUX][$];
    int    rr_m;
    int    g_m;
    bit    any_m;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int f = 0; f < FLUX; f++) mq[f].delete();
        rr_m  = 0;
        any_m = 1'b0;
    endtask

    // Reference model: per-flux queues plus a round-robin index, evaluated once per cycle.
    initial begin
        exp_t e;
        int   pre [FLUX];
        model_clear();
        forever begin
            @(negedge clk);
            if (rst) model_clear();
            any_m = 1'b0;
            g_m   = 0;
            for (int k = 0; k < FLUX; k++) begin
                int f;
                f = (rr_m + k) % FLUX;
                if (!any_m && mq[f].size() > 0 && !bus.out_port_full[f]) begin
                    any_m = 1'b1;
                    g_m   = f;
                end
            end
            e.w = any_m;
            e.d = any_m ? {tag_t'(g_m), mq[g_m][0]} : '0;
            for (int f = 0; f < FLUX; f++) e.inf[f] = (mq[f].size() == DEPTH);
            sbq.push_back(e);
            @(posedge clk);
            if (rst) begin
                model_clear();
            end else begin
                for (int f = 0; f < FLUX; f++) pre[f] = mq[f].size();
                if (any_m) begin
                    void'(mq[g_m].pop_front());
                    rr_m = (g_m + 1) % FLUX;
                end
                for (int f = 0; f < FLUX; f++) begin
                    if (bus.in_port_write[f] && pre[f] < DEPTH)
                        mq[f].push_back(bus.in_port_datain[f*DATA_WIDTH +: DATA_WIDTH]);
                end
            end
        end
    end

    // Monitor: compares what the DUT presents each cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sbq.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sbq.pop_front();
                chk("out_write", 32'(bus.out_port_write), 32'(e.w));
                chk("out_data", 32'(bus.out_port_dataout), 32'(e.d));
                chk("in_full", 32'(bus.in_port_full), 32'(e.inf));
            end
        end
    end

    task automatic drive(input logic [1:0] w, input data_t d0, input data_t d1, input logic [1:0] f);
        bus.in_port_write  = w;
        bus.in_port_datain = {d1, d0};
        bus.out_port_full  = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [1:0] f);
        for (int i = 0; i < n; i++) drive(2'b00, 8'h00, 8'h00, f);
    endtask

    initial begin
        rst                = 1'b1;
        bus.in_port_write  = '0;
        bus.in_port_datain = '0;
        bus.out_port_full  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single flux, two words.
        drive(2'b10, 8'h00, 8'h11, 2'b00);
        drive(2'b10, 8'h00, 8'h22, 2'b00);
        idle(4, 2'b00);

        // Fairness: preload both fluxes while blocked, then release.
        for (int i = 0; i < 4; i++) drive(2'b11, 8'hA0 + 8'(i), 8'hB0 + 8'(i), 2'b11);
        idle(10, 2'b00);

        // Per-flux backpressure on flux 0 only.
        for (int i = 0; i < 3; i++) drive(2'b11, 8'h50 + 8'(i), 8'h60 + 8'(i), 2'b01);
        idle(4, 2'b01);
        idle(6, 2'b00);

        // Full/drop: fifth write to flux 0 is dropped.
        for (int i = 0; i < 5; i++) drive(2'b01, 8'hC0 + 8'(i), 8'h00, 2'b11);
        idle(2, 2'b11);
        idle(8, 2'b00);

        // Reset mid-stream with words buffered and eligible.
        for (int i = 0; i < 3; i++) drive(2'b01, 8'hD0 + 8'(i), 8'h00, 2'b11);
        bus.out_port_full = 2'b00;
        rst = 1'b1;
        #1;
        chk("rst_async_write", 32'(bus.out_port_write), 32'd0);
        chk("rst_async_data", 32'(bus.out_port_dataout), 32'd0);
        chk("rst_async_full", 32'(bus.in_port_full), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6, 2'b00);

        // Random traffic with random per-flux backpressure.
        for (int i = 0; i < 1500; i++) begin
            logic [1:0] w;
            logic [1:0] f;
            w = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom);
            f = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            drive(w, 8'($urandom), 8'($urandom), f);
        end
        idle(12, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
